pc_branch_unit: RTL and testbench
=================================

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] are forced to 0 internally.
REQ-002 Parameter: FLUSH_CYCLES, 1, number of cycles flush stays high after a redirect; legal range 1..7.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: stall  input  1  hold request from the downstream pipeline.
REQ-006 Port: branchMux  input  1  taken-branch decision (zero AND pcSrc) from the branch gate.
REQ-007 Port: branchOffset  input  16  signed word offset of the conditional branch.
REQ-008 Port: jump  input  1  unconditional jump request.
REQ-009 Port: jumpTarget  input  26  word-address field of the jump.
REQ-010 Port: pc  output  32  registered current fetch address.
REQ-011 Port: pcPlus4  output  32  combinational pc + 4.
REQ-012 Port: flush  output  1  registered; discard the wrong-path instruction in flight.
REQ-013 Port: takenCount  output  8  registered count of accepted redirects; saturates at 255.

Function
REQ-014 The unit SHALL implement a two-state FSM: RUN and FLUSH.
REQ-015 RUN, stall=0, no redirect: pc <= pc + 4 (mod 2^32); stay in RUN.
REQ-016 RUN, stall=1: pc, takenCount and state SHALL hold; branchMux and jump SHALL be ignored.
REQ-017 Branch target = pcPlus4 + (sign-extended branchOffset << 2), mod 2^32; wrap past 32'hFFFF_FFFC or below 0 is legal.
REQ-018 Jump target = {pcPlus4[31:28], jumpTarget, 2'b00}.
REQ-019 RUN, stall=0, jump=1: pc <= jump target; this SHALL take priority over branchMux when both are high.
REQ-020 RUN, stall=0, branchMux=1, jump=0: pc <= branch target.
REQ-021 Any accepted redirect SHALL move the FSM to FLUSH, load a down-counter with FLUSH_CYCLES, and increment takenCount unless it is 255.
REQ-022 flush SHALL be 1 exactly during the FLUSH_CYCLES cycles after the redirect edge, and 0 in RUN.
REQ-023 In FLUSH, pc SHALL hold the target; branchMux and jump SHALL be ignored; stall SHALL NOT pause the countdown.
REQ-024 When the counter reaches the last flush cycle, the FSM SHALL return to RUN on the next edge, and flush SHALL fall on that edge.
REQ-025 In the first RUN cycle after FLUSH, pc SHALL advance by 4, or redirect again, under REQ-015 to REQ-020.
REQ-026 pc[1:0] SHALL always be 0.

Reset
REQ-027 With reset=1 at a rising edge, the following SHALL hold regardless of all other inputs, including mid-FLUSH: pc = RESET_PC & ~3, flush = 0, takenCount = 0, FSM = RUN, flush counter = 0.
REQ-028 The first increment after reset SHALL occur on the first rising edge with reset=0 and stall=0.

Verification
REQ-029 Sequential fetch: release reset, stall=0, no redirects for 4 cycles -> pc = 0x0, 0x4, 0x8, 0xC; flush = 0; takenCount = 0.
REQ-030 Forward/backward branch: at pc=0x10, branchMux=1 with offset 16'h0003 -> pc = 0x20, flush = 1 for 1 cycle, takenCount = 1; then at pc=0x24, offset 16'hFFFE -> pc = 0x20, takenCount = 2.
REQ-031 Jump priority: at pc=0x1000_0008, jump=1 with jumpTarget=26'h0000040 and branchMux=1 together -> pc = 0x1000_0100; takenCount increments by exactly 1.
REQ-032 Stall vs flush: FLUSH_CYCLES=3; redirect, then stall=1 and branchMux=1 throughout -> flush high for exactly 3 cycles, pc held at target, no second redirect; stall held after return to RUN -> pc holds.
REQ-033 Wrap and saturation: at pc=0xFFFF_FFFC with no redirect -> pc = 0x0; after 300 accepted redirects -> takenCount = 255.
REQ-034 Reset mid-FLUSH: FLUSH_CYCLES=4, reset asserted in the 2nd flush cycle -> next edge gives pc = RESET_PC, flush = 0, takenCount = 0.

Source files
------------

// File: rtl/pc_branch_unit.sv
// Program counter with branch/jump redirect, post-redirect flush window
// and a saturating count of taken redirects.
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchMux,
  input  logic [15:0] branchOffset,
  input  logic        jump,
  input  logic [25:0] jumpTarget,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        flush,
  output logic [7:0]  takenCount
);

  localparam int unsigned CntW = 3;
  localparam int unsigned PcW  = 32;
  localparam logic [PcW-1:0] ResetPcAligned = {RESET_PC[PcW-1:2], 2'b00};

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state, stateNext;
  logic [CntW-1:0] flushCnt, flushCntNext;
  logic [PcW-1:0]  pcNext;
  logic            flushNext;
  logic [7:0]      takenCountNext;
  logic [PcW-1:0]  branchAddr;
  logic [PcW-1:0]  jumpAddr;

  assign pcPlus4    = pc + PcW'(4);
  assign branchAddr = pcPlus4 + {{14{branchOffset[15]}}, branchOffset, 2'b00};
  assign jumpAddr   = {pcPlus4[31:28], jumpTarget, 2'b00};

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      flushCnt   <= '0;
      pc         <= ResetPcAligned;
      flush      <= 1'b0;
      takenCount <= '0;
    end else begin
      state      <= stateNext;
      flushCnt   <= flushCntNext;
      pc         <= pcNext;
      flush      <= flushNext;
      takenCount <= takenCountNext;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    stateNext      = state;
    flushCntNext   = flushCnt;
    pcNext         = pc;
    flushNext      = 1'b0;
    takenCountNext = takenCount;
    case (state)
      RUN: begin
        if (!stall) begin
          if (jump || branchMux) begin
            pcNext       = jump ? jumpAddr : branchAddr;
            stateNext    = FLUSH;
            flushCntNext = CntW'(FLUSH_CYCLES);
            flushNext    = 1'b1;
            if (takenCount != 8'hFF) takenCountNext = takenCount + 8'd1;
          end else begin
            pcNext = pcPlus4;
          end
        end
      end
      FLUSH: begin
        // Countdown ignores stall; flush drops on the edge leaving FLUSH
        if (flushCnt <= CntW'(1)) begin
          stateNext    = RUN;
          flushCntNext = '0;
        end else begin
          flushCntNext = flushCnt - CntW'(1);
          flushNext    = 1'b1;
        end
      end
      default: stateNext = RUN;
    endcase
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: vector table plus hand sequences, three
// instances with different FLUSH_CYCLES/RESET_PC sharing one stimulus bus.
module tb_pc_branch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branchMux = 1'b0;
  logic [15:0] branchOffset = '0;
  logic        jump = 1'b0;
  logic [25:0] jumpTarget = '0;

  logic [31:0] pc1, pcPlus41, pc3, pcPlus43, pc4, pcPlus44;
  logic        flush1, flush3, flush4;
  logic [7:0]  taken1, taken3, taken4;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pc_branch_unit #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .branchMux(branchMux),
    .branchOffset(branchOffset), .jump(jump), .jumpTarget(jumpTarget),
    .pc(pc1), .pcPlus4(pcPlus41), .flush(flush1), .takenCount(taken1));

  pc_branch_unit #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .stall(stall), .branchMux(branchMux),
    .branchOffset(branchOffset), .jump(jump), .jumpTarget(jumpTarget),
    .pc(pc3), .pcPlus4(pcPlus43), .flush(flush3), .takenCount(taken3));

  pc_branch_unit #(.RESET_PC(32'h1000_0003), .FLUSH_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .branchMux(branchMux),
    .branchOffset(branchOffset), .jump(jump), .jumpTarget(jumpTarget),
    .pc(pc4), .pcPlus4(pcPlus44), .flush(flush4), .takenCount(taken4));

  typedef struct {
    logic        rst;
    logic        stl;
    logic        br;
    logic [15:0] off;
    logic        jmp;
    logic [25:0] jt;
    logic [31:0] ePc;
    logic        eFl;
    logic [7:0]  eTc;
  } vec_t;

  typedef struct {
    int          sel;
    logic [31:0] pc;
    logic        fl;
    logic [7:0]  tc;
    string       name;
  } exp_t;

  vec_t vecs[21];
  exp_t sbq[$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endtask

  task automatic checkOut();
    exp_t        e;
    logic [31:0] aPc, aP4;
    logic        aFl;
    logic [7:0]  aTc;
    e = sbq.pop_front();
    case (e.sel)
      3:       begin aPc = pc3; aP4 = pcPlus43; aFl = flush3; aTc = taken3; end
      4:       begin aPc = pc4; aP4 = pcPlus44; aFl = flush4; aTc = taken4; end
      default: begin aPc = pc1; aP4 = pcPlus41; aFl = flush1; aTc = taken1; end
    endcase
    cmp({e.name, ".pc"}, aPc, e.pc);
    cmp({e.name, ".pcPlus4"}, aP4, e.pc + 32'd4);
    cmp({e.name, ".flush"}, {31'd0, aFl}, {31'd0, e.fl});
    cmp({e.name, ".takenCount"}, {24'd0, aTc}, {24'd0, e.tc});
  endtask

  // Drive one cycle of stimulus, queue its expectation, check after the edge
  task automatic apply(input logic r, input logic s, input logic b, input logic [15:0] o,
                       input logic j, input logic [25:0] t, input int sel,
                       input logic [31:0] ePc, input logic eFl, input logic [7:0] eTc,
                       input string nm);
    exp_t e;
    reset = r; stall = s; branchMux = b; branchOffset = o; jump = j; jumpTarget = t;
    e.sel = sel; e.pc = ePc; e.fl = eFl; e.tc = eTc; e.name = nm;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    checkOut();
  endtask

  initial begin
    logic [31:0] mPc;
    logic [7:0]  mTc;

    vecs[0]  = '{0, 0, 0, 16'h0000, 0, 26'h0,       32'h0000_0004, 0, 8'd0};
    vecs[1]  = '{0, 0, 0, 16'h0000, 0, 26'h0,       32'h0000_0008, 0, 8'd0};
    vecs[2]  = '{0, 0, 0, 16'h0000, 0, 26'h0,       32'h0000_000C, 0, 8'd0};
    vecs[3]  = '{0, 0, 0, 16'h0000, 0, 26'h0,       32'h0000_0010, 0, 8'd0};
    vecs[4]  = '{0, 0, 1, 16'h0003, 0, 26'h0,       32'h0000_0020, 1, 8'd1};
    vecs[5]  = '{0, 0, 1, 16'h0003, 1, 26'h3FFFFFF, 32'h0000_0020, 0, 8'd1};
    vecs[6]  = '{0, 0, 0, 16'h0000, 0, 26'h0,       32'h0000_0024, 0, 8'd1};
    vecs[7]  = '{0, 0, 1, 16'hFFFE, 0, 26'h0,       32'h0000_0020, 1, 8'd2};
    vecs[8]  = '{0, 0, 0, 16'h0000, 0, 26'h0,       32'h0000_0020, 0, 8'd2};
    vecs[9]  = '{0, 1, 1, 16'h0004, 1, 26'h40,      32'h0000_0020, 0, 8'd2};
    vecs[10] = '{0, 0, 1, 16'h0005, 1, 26'h40,      32'h0000_0100, 1, 8'd3};
    vecs[11] = '{0, 1, 0, 16'h0000, 0, 26'h0,       32'h0000_0100, 0, 8'd3};
    vecs[12] = '{0, 0, 1, 16'h8000, 0, 26'h0,       32'hFFFE_0104, 1, 8'd4};
    vecs[13] = '{0, 0, 0, 16'h0000, 0, 26'h0,       32'hFFFE_0104, 0, 8'd4};
    vecs[14] = '{0, 0, 0, 16'h0000, 1, 26'h3FFFFFF, 32'hFFFF_FFFC, 1, 8'd5};
    vecs[15] = '{0, 0, 0, 16'h0000, 0, 26'h0,       32'hFFFF_FFFC, 0, 8'd5};
    vecs[16] = '{0, 0, 0, 16'h0000, 0, 26'h0,       32'h0000_0000, 0, 8'd5};
    vecs[17] = '{0, 0, 1, 16'hFFFE, 0, 26'h0,       32'hFFFF_FFFC, 1, 8'd6};
    vecs[18] = '{0, 0, 0, 16'h0000, 0, 26'h0,       32'hFFFF_FFFC, 0, 8'd6};
    vecs[19] = '{0, 0, 1, 16'h0001, 0, 26'h0,       32'h0000_0004, 1, 8'd7};
    vecs[20] = '{1, 0, 1, 16'h0001, 1, 26'h1,       32'h0000_0000, 0, 8'd0};

    // Reset state of the default instance
    apply(1, 0, 1, 16'h0003, 1, 26'h1, 1, 32'h0, 0, 8'd0, "reset1");
    apply(1, 0, 0, 16'h0000, 0, 26'h0, 1, 32'h0, 0, 8'd0, "reset2");

    for (int i = 0; i < 21; i++)
      apply(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].off, vecs[i].jmp, vecs[i].jt,
            1, vecs[i].ePc, vecs[i].eFl, vecs[i].eTc, $sformatf("vec%0d", i));

    // Saturation: 300 redirects, each followed by its flush cycle
    mPc = 32'h0;
    mTc = 8'd0;
    for (int i = 0; i < 300; i++) begin
      mPc = mPc + 32'd4;
      if (mTc != 8'd255) mTc = mTc + 8'd1;
      apply(0, 0, 1, 16'h0000, 0, 26'h0, 1, mPc, 1, mTc, $sformatf("sat%0d", i));
      apply(0, 0, 0, 16'h0000, 0, 26'h0, 1, mPc, 0, mTc, $sformatf("satf%0d", i));
    end
    cmp("satFinal", {24'd0, taken1}, 32'd255);

    // Stall against a 3-cycle flush window
    apply(1, 0, 0, 16'h0000, 0, 26'h0, 3, 32'h0,  0, 8'd0, "st.reset");
    apply(0, 0, 0, 16'h0000, 0, 26'h0, 3, 32'h4,  0, 8'd0, "st.inc");
    apply(0, 0, 1, 16'h0002, 0, 26'h0, 3, 32'h10, 1, 8'd1, "st.redir");
    apply(0, 1, 1, 16'h0002, 0, 26'h0, 3, 32'h10, 1, 8'd1, "st.fl2");
    apply(0, 1, 1, 16'h0002, 0, 26'h0, 3, 32'h10, 1, 8'd1, "st.fl3");
    apply(0, 1, 1, 16'h0002, 0, 26'h0, 3, 32'h10, 0, 8'd1, "st.run");
    apply(0, 1, 1, 16'h0002, 0, 26'h0, 3, 32'h10, 0, 8'd1, "st.hold1");
    apply(0, 1, 1, 16'h0002, 1, 26'h0, 3, 32'h10, 0, 8'd1, "st.hold2");

    // Jump priority, then reset in the second flush cycle
    apply(1, 0, 0, 16'h0000, 0, 26'h0,  4, 32'h1000_0000, 0, 8'd0, "rf.reset");
    apply(0, 0, 0, 16'h0000, 0, 26'h0,  4, 32'h1000_0004, 0, 8'd0, "rf.inc1");
    apply(0, 0, 0, 16'h0000, 0, 26'h0,  4, 32'h1000_0008, 0, 8'd0, "rf.inc2");
    apply(0, 0, 1, 16'h0003, 1, 26'h40, 4, 32'h1000_0100, 1, 8'd1, "rf.jump");
    apply(0, 0, 0, 16'h0000, 0, 26'h0,  4, 32'h1000_0100, 1, 8'd1, "rf.fl2");
    apply(1, 0, 1, 16'h0003, 1, 26'h40, 4, 32'h1000_0000, 0, 8'd0, "rf.midReset");
    apply(0, 0, 0, 16'h0000, 0, 26'h0,  4, 32'h1000_0004, 0, 8'd0, "rf.after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
